// File: rtl/updown_bound_counter_if.sv
// Bus interface for updown_bound_counter.
// Groups the control inputs and the count/status outputs.
// The wrap_cnt signal exists only when UDC_WRAP_COUNT_EN is defined.
interface updown_bound_counter_if #(
  parameter int WIDTH     = 5,
  parameter int WRAPCNT_W = 8
);

  logic             en;
  logic             mode;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] counter;
  logic             wrap;
  logic             at_lo;
  logic             at_hi;
  logic             bnd_err;
`ifdef UDC_WRAP_COUNT_EN
  logic [WRAPCNT_W-1:0] wrap_cnt;
`endif

  // Controller side: drives the controls and observes the count.
  modport master (
    output en, mode, sat, load, load_val, lo, hi,
`ifdef UDC_WRAP_COUNT_EN
    input  wrap_cnt,
`endif
    input  counter, wrap, at_lo, at_hi, bnd_err
  );

  // Counter side.
  modport slave (
    input  en, mode, sat, load, load_val, lo, hi,
`ifdef UDC_WRAP_COUNT_EN
    output wrap_cnt,
`endif
    output counter, wrap, at_lo, at_hi, bnd_err
  );

endinterface

// File: rtl/updown_bound_counter.sv
// updown_bound_counter: up/down counter with run-time lo/hi bounds,
// count enable, clamped parallel load and wrap/saturate selection.
// Optional feature macro: UDC_WRAP_COUNT_EN adds a saturating wrap_cnt
// output counting wrap steps (cleared by load).
module updown_bound_counter #(
  parameter int               WIDTH     = 5,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter int               WRAPCNT_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  updown_bound_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             bndErr;
  logic             wrapStep;
  logic             loadTake;

  assign bndErr = (bus.lo > bus.hi);

  // Next count: bound error freezes everything, then load, then counting.
  // The >= / <= tests also pull an out-of-range count back inside.
  always_comb begin
    count_d  = count_q;
    wrapStep = 1'b0;
    loadTake = 1'b0;
    if (bndErr) begin
      count_d = count_q;
    end else if (bus.load) begin
      loadTake = 1'b1;
      if (bus.load_val > bus.hi) begin
        count_d = bus.hi;
      end else if (bus.load_val < bus.lo) begin
        count_d = bus.lo;
      end else begin
        count_d = bus.load_val;
      end
    end else if (bus.en) begin
      if (bus.mode) begin
        if (count_q < bus.hi) begin
          count_d = count_q + ONE;
        end else begin
          count_d  = bus.sat ? bus.hi : bus.lo;
          wrapStep = ~bus.sat;
        end
      end else begin
        if (count_q > bus.lo) begin
          count_d = count_q - ONE;
        end else begin
          count_d  = bus.sat ? bus.lo : bus.hi;
          wrapStep = ~bus.sat;
        end
      end
    end
    wrap_d = wrapStep;
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_VAL;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef UDC_WRAP_COUNT_EN
  logic [WRAPCNT_W-1:0] wrapCnt_q;
  logic [WRAPCNT_W-1:0] wrapCnt_d;

  // Wrap tally: cleared by an accepted load, sticks at all-ones.
  always_comb begin
    wrapCnt_d = wrapCnt_q;
    if (loadTake) begin
      wrapCnt_d = '0;
    end else if (wrapStep && !(&wrapCnt_q)) begin
      wrapCnt_d = wrapCnt_q + WRAPCNT_W'(1);
    end
  end

  // Wrap tally register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrapCnt_q <= '0;
    end else begin
      wrapCnt_q <= wrapCnt_d;
    end
  end

  assign bus.wrap_cnt = wrapCnt_q;
`else
  logic unusedLoad;
  assign unusedLoad = loadTake;
`endif

  assign bus.counter = count_q;
  assign bus.wrap    = wrap_q;
  assign bus.at_lo   = (count_q <= bus.lo);
  assign bus.at_hi   = (count_q >= bus.hi);
  assign bus.bnd_err = bndErr;

endmodule

// File: tb/tb_updown_bound_counter.sv
// Testbench for updown_bound_counter: directed vectors, a behavioural
// model checked every falling edge, and literal expectations.
module tb_updown_bound_counter;

  localparam int WIDTH     = 5;
  localparam int WRAPCNT_W = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  updown_bound_counter_if #(.WIDTH(WIDTH), .WRAPCNT_W(WRAPCNT_W)) bus ();

  updown_bound_counter #(
    .WIDTH    (WIDTH),
    .RST_VAL  ('0),
    .WRAPCNT_W(WRAPCNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model state: plain integers.
  int mCount   = 0;
  int mWrap    = 0;
  int mWrapCnt = 0;
  int mLo, mHi, mVal, mNext, mWrapped;

  // Model update: applies the counter rules with integer arithmetic.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mCount   = 0;
      mWrap    = 0;
      mWrapCnt = 0;
    end else begin
      mLo      = int'(bus.lo);
      mHi      = int'(bus.hi);
      mVal     = int'(bus.load_val);
      mNext    = mCount;
      mWrapped = 0;
      if (mLo > mHi) begin
        mNext = mCount;
      end else if (bus.load) begin
        mNext    = (mVal < mLo) ? mLo : ((mVal > mHi) ? mHi : mVal);
        mWrapCnt = 0;
      end else if (bus.en && bus.mode) begin
        if (mCount + 1 <= mHi) mNext = mCount + 1;
        else if (bus.sat) mNext = mHi;
        else begin mNext = mLo; mWrapped = 1; end
      end else if (bus.en) begin
        if (mCount - 1 >= mLo) mNext = mCount - 1;
        else if (bus.sat) mNext = mLo;
        else begin mNext = mHi; mWrapped = 1; end
      end
      mCount = mNext;
      mWrap  = mWrapped;
      if (mWrapped != 0 && mWrapCnt < (1 << WRAPCNT_W) - 1) mWrapCnt = mWrapCnt + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("model.counter", 32'(bus.counter), 32'(mCount));
    checkOutput("model.wrap",    32'(bus.wrap),    32'(mWrap));
    checkOutput("model.at_lo",   32'(bus.at_lo),   32'(mCount <= int'(bus.lo)));
    checkOutput("model.at_hi",   32'(bus.at_hi),   32'(mCount >= int'(bus.hi)));
    checkOutput("model.bnd_err", 32'(bus.bnd_err), 32'(int'(bus.lo) > int'(bus.hi)));
`ifdef UDC_WRAP_COUNT_EN
    checkOutput("model.wrap_cnt", 32'(bus.wrap_cnt), 32'(mWrapCnt));
`endif
  end

  task automatic applyStimulus(input int en, input int mode, input int sat, input int load,
                               input int loadVal, input int lo, input int hi);
    bus.en       = en[0];
    bus.mode     = mode[0];
    bus.sat      = sat[0];
    bus.load     = load[0];
    bus.load_val = WIDTH'(loadVal);
    bus.lo       = WIDTH'(lo);
    bus.hi       = WIDTH'(hi);
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    applyStimulus(1, 1, 0, 0, 0, 0, 30);
    #12;
    checkOutput("reset.counter", 32'(bus.counter), 0);
    checkOutput("reset.wrap",    32'(bus.wrap), 0);
    rst_n = 1'b1;

    // Count up 0..30 then wrap to 0.
    stepCycles(1);
    checkOutput("up.first", 32'(bus.counter), 1);
    stepCycles(29);
    checkOutput("up.top", 32'(bus.counter), 30);
    checkOutput("up.top_wrap", 32'(bus.wrap), 0);
    stepCycles(1);
    checkOutput("up.wrapped", 32'(bus.counter), 0);
    checkOutput("up.wrap_pulse", 32'(bus.wrap), 1);
    stepCycles(1);
    checkOutput("up.after_wrap", 32'(bus.counter), 1);
    checkOutput("up.pulse_clear", 32'(bus.wrap), 0);

    // Count down through zero to hi.
    applyStimulus(1, 0, 0, 0, 0, 0, 30);
    stepCycles(1);
    checkOutput("down.zero", 32'(bus.counter), 0);
    stepCycles(1);
    checkOutput("down.wrapped", 32'(bus.counter), 30);
    checkOutput("down.wrap_pulse", 32'(bus.wrap), 1);
    stepCycles(2);
    checkOutput("down.28", 32'(bus.counter), 28);

    // Saturate at hi.
    applyStimulus(1, 1, 1, 0, 0, 0, 30);
    stepCycles(2);
    checkOutput("sat.30", 32'(bus.counter), 30);
    checkOutput("sat.at_hi", 32'(bus.at_hi), 1);
    stepCycles(2);
    checkOutput("sat.hold", 32'(bus.counter), 30);
    checkOutput("sat.no_wrap", 32'(bus.wrap), 0);

    // Clamped loads; load beats en.
    applyStimulus(0, 1, 0, 1, 2, 0, 30);
    stepCycles(1);
    checkOutput("load.2", 32'(bus.counter), 2);
    applyStimulus(0, 1, 0, 1, 31, 0, 30);
    stepCycles(1);
    checkOutput("load.clamp_hi", 32'(bus.counter), 30);
    applyStimulus(0, 1, 0, 1, 2, 5, 30);
    stepCycles(1);
    checkOutput("load.clamp_lo", 32'(bus.counter), 5);
    applyStimulus(1, 1, 0, 1, 7, 0, 30);
    stepCycles(1);
    checkOutput("load.over_en", 32'(bus.counter), 7);

    // Out-of-range resolution, then bound error freeze.
    applyStimulus(0, 1, 0, 1, 20, 0, 30);
    stepCycles(1);
    checkOutput("oor.load20", 32'(bus.counter), 20);
    applyStimulus(1, 1, 0, 0, 0, 5, 10);
    stepCycles(1);
    checkOutput("oor.to_lo", 32'(bus.counter), 5);
    checkOutput("oor.wrap", 32'(bus.wrap), 1);
    applyStimulus(1, 1, 0, 1, 9, 12, 3);
    #1;
    checkOutput("bnd.flag", 32'(bus.bnd_err), 1);
    stepCycles(2);
    checkOutput("bnd.hold", 32'(bus.counter), 5);
    checkOutput("bnd.no_wrap", 32'(bus.wrap), 0);

    // lo==hi: every step is a wrap step, wrap stays high.
    applyStimulus(0, 1, 0, 1, 5, 7, 7);
    stepCycles(1);
    checkOutput("pin.load", 32'(bus.counter), 7);
    applyStimulus(1, 1, 0, 0, 0, 7, 7);
    stepCycles(2);
    checkOutput("pin.wrap_held", 32'(bus.wrap), 1);
    stepCycles(1);
    checkOutput("pin.count", 32'(bus.counter), 7);
    checkOutput("pin.wrap_still", 32'(bus.wrap), 1);
`ifdef UDC_WRAP_COUNT_EN
    checkOutput("wcnt.three", 32'(bus.wrap_cnt), 3);
`endif
    applyStimulus(0, 1, 0, 1, 7, 7, 7);
    stepCycles(1);
    checkOutput("pin.load_clear", 32'(bus.wrap), 0);
`ifdef UDC_WRAP_COUNT_EN
    checkOutput("wcnt.cleared", 32'(bus.wrap_cnt), 0);
`endif

    // Asynchronous reset between edges.
    applyStimulus(0, 1, 0, 1, 17, 0, 30);
    stepCycles(1);
    checkOutput("arst.pre", 32'(bus.counter), 17);
    applyStimulus(1, 1, 0, 0, 0, 0, 30);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst.counter", 32'(bus.counter), 0);
    checkOutput("arst.wrap", 32'(bus.wrap), 0);
    #1;
    rst_n = 1'b1;
    stepCycles(1);
    checkOutput("arst.resume", 32'(bus.counter), 1);

    // Down from below lo: saturate then wrap.
    applyStimulus(1, 0, 1, 0, 0, 5, 10);
    stepCycles(1);
    checkOutput("below.sat", 32'(bus.counter), 5);
    applyStimulus(1, 0, 0, 0, 0, 8, 10);
    stepCycles(1);
    checkOutput("below.wrap_to_hi", 32'(bus.counter), 10);
    checkOutput("below.wrap", 32'(bus.wrap), 1);

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
